// File: rtl/mpt_plb.sv
// Protection lookaside buffer: NUM_ENTRIES cached MPT leaf entries (64 KiB, 16 pages each)
// tagged by SDID, with 1-cycle lookups, walker refills, global/per-SDID flush and statistics.
module mpt_plb #(
  parameter int XLEN        = 64,
  parameter int SDID_LEN    = 6,
  parameter int NUM_ENTRIES = 8,
  parameter int CNT_W       = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                lkp_valid_i,
  output logic                lkp_ready_o,
  input  logic [SDID_LEN-1:0] lkp_sdid_i,
  input  logic [XLEN-1:0]     lkp_spa_i,
  input  logic [1:0]          lkp_access_i,
  output logic                rsp_valid_o,
  output logic                rsp_hit_o,
  output logic [2:0]          rsp_perms_o,
  output logic                rsp_allow_o,
  input  logic                fill_valid_i,
  output logic                fill_ready_o,
  input  logic [SDID_LEN-1:0] fill_sdid_i,
  input  logic [XLEN-1:0]     fill_spa_i,
  input  logic [47:0]         fill_perms_i,
  input  logic                flush_valid_i,
  input  logic                flush_all_i,
  input  logic [SDID_LEN-1:0] flush_sdid_i,
  output logic                flush_done_o,
  output logic [CNT_W-1:0]    hit_cnt_o,
  output logic [CNT_W-1:0]    miss_cnt_o
);
  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int TAG_W = XLEN - 16;

  typedef enum logic [1:0] {
    ACCESS_NONE  = 2'd0,
    ACCESS_READ  = 2'd1,
    ACCESS_WRITE = 2'd2,
    ACCESS_EXEC  = 2'd3
  } mpt_access_e;

  logic [NUM_ENTRIES-1:0] valid;
  logic [SDID_LEN-1:0]    sdid  [NUM_ENTRIES];
  logic [TAG_W-1:0]       tag   [NUM_ENTRIES];
  logic [47:0]            perms [NUM_ENTRIES];
  logic [IDX_W-1:0]       rr_ptr;

  logic             lkp_acc, fill_acc;
  logic [TAG_W-1:0] lkp_tag, fill_tag;
  logic             lkp_hit, fill_hit, any_inv;
  logic [IDX_W-1:0] lkp_idx, fill_hit_idx, inv_idx, fill_idx;
  logic [47:0]      lkp_line;
  logic [2:0]       page_perm;
  logic             allow;
  logic             unused_spa_bits;

  assign lkp_ready_o  = !flush_valid_i;
  assign fill_ready_o = !flush_valid_i;
  assign lkp_acc      = lkp_valid_i && !flush_valid_i;
  assign fill_acc     = fill_valid_i && !flush_valid_i;
  assign lkp_tag      = lkp_spa_i[XLEN-1:16];
  assign fill_tag     = fill_spa_i[XLEN-1:16];
  assign unused_spa_bits = ^{lkp_spa_i[11:0], fill_spa_i[15:0]};

  // Descending scan so the lowest-index invalid entry wins.
  always_comb begin
    lkp_hit      = 1'b0;
    lkp_idx      = '0;
    fill_hit     = 1'b0;
    fill_hit_idx = '0;
    any_inv      = 1'b0;
    inv_idx      = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (valid[i] && sdid[i] == lkp_sdid_i && tag[i] == lkp_tag) begin
        lkp_hit = 1'b1;
        lkp_idx = IDX_W'(i);
      end
      if (valid[i] && sdid[i] == fill_sdid_i && tag[i] == fill_tag) begin
        fill_hit     = 1'b1;
        fill_hit_idx = IDX_W'(i);
      end
      if (!valid[i]) begin
        any_inv = 1'b1;
        inv_idx = IDX_W'(i);
      end
    end
  end

  assign fill_idx = fill_hit ? fill_hit_idx : (any_inv ? inv_idx : rr_ptr);

  always_comb begin
    lkp_line  = perms[lkp_idx];
    page_perm = '0;
    for (int p = 0; p < 16; p++) begin
      if (lkp_spa_i[15:12] == 4'(p)) page_perm = lkp_line[3*p +: 3];
    end
    allow = 1'b0;
    // W without R is a reserved encoding and grants nothing.
    if (page_perm != 3'b010 && page_perm != 3'b110) begin
      case (mpt_access_e'(lkp_access_i))
        ACCESS_READ:  allow = page_perm[0];
        ACCESS_WRITE: allow = page_perm[1];
        ACCESS_EXEC:  allow = page_perm[2];
        default:      allow = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill_acc) begin
      sdid[fill_idx]  <= fill_sdid_i;
      tag[fill_idx]   <= fill_tag;
      perms[fill_idx] <= fill_perms_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid        <= '0;
      rr_ptr       <= '0;
      rsp_valid_o  <= 1'b0;
      rsp_hit_o    <= 1'b0;
      rsp_perms_o  <= '0;
      rsp_allow_o  <= 1'b0;
      flush_done_o <= 1'b0;
      hit_cnt_o    <= '0;
      miss_cnt_o   <= '0;
    end else begin
      flush_done_o <= flush_valid_i;
      rsp_valid_o  <= lkp_acc;
      rsp_hit_o    <= lkp_acc && lkp_hit;
      rsp_perms_o  <= (lkp_acc && lkp_hit) ? page_perm : 3'b000;
      rsp_allow_o  <= lkp_acc && lkp_hit && allow;

      if (flush_valid_i) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
          if (flush_all_i || sdid[i] == flush_sdid_i) valid[i] <= 1'b0;
        end
      end else if (fill_valid_i) begin
        valid[fill_idx] <= 1'b1;
        if (!fill_hit && !any_inv) rr_ptr <= rr_ptr + 1'b1;
      end

      if (lkp_acc) begin
        if (lkp_hit) begin
          if (hit_cnt_o != {CNT_W{1'b1}}) hit_cnt_o <= hit_cnt_o + 1'b1;
        end else begin
          if (miss_cnt_o != {CNT_W{1'b1}}) miss_cnt_o <= miss_cnt_o + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mpt_plb.sv
// Scoreboard bench for mpt_plb: directed stimulus pushes expected responses,
// a negedge monitor pops and compares each response.
module tb_mpt_plb;
  localparam int XLEN = 64, SDID_LEN = 6, NUM_ENTRIES = 8, CNT_W = 4;
  localparam int CNT_MAX = 15;
  localparam logic [1:0] A_NONE = 2'd0, A_READ = 2'd1, A_WRITE = 2'd2, A_EXEC = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst = 1'b1;
  logic                lkp_valid = 1'b0, lkp_ready;
  logic [SDID_LEN-1:0] lkp_sdid = '0;
  logic [XLEN-1:0]     lkp_spa = '0;
  logic [1:0]          lkp_access = '0;
  logic                rsp_valid, rsp_hit, rsp_allow;
  logic [2:0]          rsp_perms;
  logic                fill_valid = 1'b0, fill_ready;
  logic [SDID_LEN-1:0] fill_sdid = '0;
  logic [XLEN-1:0]     fill_spa = '0;
  logic [47:0]         fill_perms = '0;
  logic                flush_valid = 1'b0, flush_all = 1'b0, flush_done;
  logic [SDID_LEN-1:0] flush_sdid = '0;
  logic [CNT_W-1:0]    hit_cnt, miss_cnt;

  mpt_plb #(.XLEN(XLEN), .SDID_LEN(SDID_LEN), .NUM_ENTRIES(NUM_ENTRIES), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .lkp_valid_i(lkp_valid), .lkp_ready_o(lkp_ready), .lkp_sdid_i(lkp_sdid),
    .lkp_spa_i(lkp_spa), .lkp_access_i(lkp_access),
    .rsp_valid_o(rsp_valid), .rsp_hit_o(rsp_hit), .rsp_perms_o(rsp_perms), .rsp_allow_o(rsp_allow),
    .fill_valid_i(fill_valid), .fill_ready_o(fill_ready), .fill_sdid_i(fill_sdid),
    .fill_spa_i(fill_spa), .fill_perms_i(fill_perms),
    .flush_valid_i(flush_valid), .flush_all_i(flush_all), .flush_sdid_i(flush_sdid),
    .flush_done_o(flush_done), .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
  );

  typedef struct {
    logic       hit;
    logic [2:0] perms;
    logic       allow;
  } exp_t;

  exp_t  sb_q[$];
  string name_q[$];
  int checks = 0, failures = 0;
  int exp_hits = 0, exp_miss = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic check_cnt(input string nm);
    check({nm, "_hit_cnt"}, 64'(hit_cnt), 64'(exp_hits));
    check({nm, "_miss_cnt"}, 64'(miss_cnt), 64'(exp_miss));
  endtask

  task automatic push(input bit h, input logic [2:0] p, input bit a, input string nm);
    exp_t e;
    e.hit   = h;
    e.perms = h ? p : 3'b000;
    e.allow = h ? a : 1'b0;
    sb_q.push_back(e);
    name_q.push_back(nm);
    if (h) begin
      if (exp_hits < CNT_MAX) exp_hits++;
    end else if (exp_miss < CNT_MAX) exp_miss++;
  endtask

  task automatic lookup(input logic [5:0] s, input logic [63:0] a, input logic [1:0] acc,
                        input bit h, input logic [2:0] p, input bit al, input string nm);
    lkp_valid = 1'b1; lkp_sdid = s; lkp_spa = a; lkp_access = acc;
    push(h, p, al, nm);
    @(posedge clk); #1;
    lkp_valid = 1'b0;
  endtask

  task automatic fill(input logic [5:0] s, input logic [63:0] a, input logic [47:0] p);
    fill_valid = 1'b1; fill_sdid = s; fill_spa = a; fill_perms = p;
    @(posedge clk); #1;
    fill_valid = 1'b0;
  endtask

  task automatic do_reset(input string nm);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_hits = 0; exp_miss = 0;
    check({nm, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check_cnt(nm);
  endtask

  // Lookup is raised together with the flush and held until accepted.
  task automatic flush_held(input bit all, input logic [5:0] fs, input logic [5:0] ls,
                            input logic [63:0] la, input string nm);
    flush_valid = 1'b1; flush_all = all; flush_sdid = fs;
    lkp_valid = 1'b1; lkp_sdid = ls; lkp_spa = la; lkp_access = A_READ;
    #1;
    check({nm, "_lkp_ready"}, 64'(lkp_ready), 64'd0);
    check({nm, "_fill_ready"}, 64'(fill_ready), 64'd0);
    @(posedge clk); #1;
    flush_valid = 1'b0;
    check({nm, "_done_high"}, 64'(flush_done), 64'd1);
    push(1'b0, 3'b000, 1'b0, {nm, "_held_lkp"});
    @(posedge clk); #1;
    lkp_valid = 1'b0;
    check({nm, "_done_pulse"}, 64'(flush_done), 64'd0);
  endtask

  initial begin : monitor
    exp_t  e;
    string n;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp actual=valid required=no_response");
        end else begin
          e = sb_q.pop_front();
          n = name_q.pop_front();
          check({n, "_hit"}, 64'(rsp_hit), 64'(e.hit));
          check({n, "_perms"}, 64'(rsp_perms), 64'(e.perms));
          check({n, "_allow"}, 64'(rsp_allow), 64'(e.allow));
        end
      end else begin
        check("idle_rsp_zero", 64'({rsp_valid, rsp_hit, rsp_perms, rsp_allow}), 64'd0);
      end
    end
  end

  initial begin : stimulus
    // Reset with flush requested: readys follow !flush_valid even in reset.
    flush_valid = 1'b1;
    #1;
    check("rst_lkp_ready_flush", 64'(lkp_ready), 64'd0);
    check("rst_fill_ready_flush", 64'(fill_ready), 64'd0);
    @(posedge clk); #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_flush_done", 64'(flush_done), 64'd0);
    check_cnt("rst");
    flush_valid = 1'b0;
    #1;
    check("rst_lkp_ready", 64'(lkp_ready), 64'd1);
    check("rst_fill_ready", 64'(fill_ready), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic fill and lookups
    fill(6'd3, 64'h1_0000, 48'h0000_0000_00C0);
    lookup(6'd3, 64'h1_2000, A_READ, 1, 3'b011, 1, "basic_read");
    lookup(6'd3, 64'h1_2000, A_EXEC, 1, 3'b011, 0, "basic_exec");
    lookup(6'd4, 64'h1_2000, A_READ, 0, 3'b000, 0, "basic_other_sdid");
    lookup(6'd3, 64'h1_3000, A_READ, 1, 3'b000, 0, "basic_page3");
    check_cnt("basic");

    // Replacement
    do_reset("repl_rst");
    for (int k = 1; k <= 8; k++) fill(6'd0, 64'(k) << 16, 48'h1);
    fill(6'd0, 64'h9_0000, 48'h1);
    lookup(6'd0, 64'h1_0000, A_READ, 0, 3'b000, 0, "repl_tag1_evicted");
    lookup(6'd0, 64'h9_0000, A_READ, 1, 3'b001, 1, "repl_tag9");
    fill(6'd0, 64'h9_0000, 48'h7);
    lookup(6'd0, 64'h9_0000, A_READ, 1, 3'b111, 1, "repl_tag9_inplace");
    lookup(6'd0, 64'h2_0000, A_READ, 1, 3'b001, 1, "repl_tag2_kept");
    fill(6'd0, 64'hA_0000, 48'h1);
    lookup(6'd0, 64'h2_0000, A_READ, 0, 3'b000, 0, "repl_tag2_evicted");
    lookup(6'd0, 64'h3_0000, A_READ, 1, 3'b001, 1, "repl_tag3_kept");
    lookup(6'd0, 64'hA_0000, A_READ, 1, 3'b001, 1, "repl_tag10");
    check_cnt("repl");

    // SDID flush
    do_reset("flush_rst");
    fill(6'd1, 64'h2_0000, 48'h1);
    fill(6'd2, 64'h2_0000, 48'h1);
    fill(6'd1, 64'h3_0000, 48'h1);
    flush_held(1'b0, 6'd1, 6'd1, 64'h2_0000, "flush_sdid1");
    lookup(6'd1, 64'h3_0000, A_READ, 0, 3'b000, 0, "flush_sdid1_miss");
    lookup(6'd2, 64'h2_0000, A_READ, 1, 3'b001, 1, "flush_sdid2_hit");
    flush_held(1'b1, 6'd0, 6'd2, 64'h2_0000, "flush_all");

    // Simultaneous lookup and fill of the same tag
    fill_valid = 1'b1; fill_sdid = 6'd5; fill_spa = 64'h4_0000; fill_perms = 48'h1;
    lkp_valid = 1'b1; lkp_sdid = 6'd5; lkp_spa = 64'h4_0000; lkp_access = A_READ;
    push(1'b0, 3'b000, 1'b0, "simul_same_cycle");
    @(posedge clk); #1;
    fill_valid = 1'b0;
    push(1'b1, 3'b001, 1'b1, "simul_next_cycle");
    @(posedge clk); #1;
    lkp_valid = 1'b0;

    // Reserved encodings and ACCESS_NONE
    fill(6'd6, 64'h5_0000, 48'h0000_0000_00F2);
    lookup(6'd6, 64'h5_0000, A_WRITE, 1, 3'b010, 0, "rsv_010_write");
    lookup(6'd6, 64'h5_1000, A_EXEC, 1, 3'b110, 0, "rsv_110_exec");
    lookup(6'd6, 64'h5_2000, A_NONE, 1, 3'b011, 0, "none_access");
    lookup(6'd6, 64'h5_2000, A_READ, 1, 3'b011, 1, "rw_read");
    lookup(6'd6, 64'h5_2000, A_WRITE, 1, 3'b011, 1, "rw_write");
    check_cnt("mixed");

    // Counter saturation and mid-stream reset
    do_reset("cnt_rst");
    fill(6'd7, 64'h6_0000, 48'h1);
    for (int k = 0; k < 20; k++) lookup(6'd7, 64'h6_0000, A_READ, 1, 3'b001, 1, "cnt_hit");
    check_cnt("cnt_sat");
    lookup(6'd7, 64'h6_0000, A_READ, 1, 3'b001, 1, "cnt_pre_rst");
    rst = 1'b1;
    lkp_valid = 1'b1; lkp_sdid = 6'd7; lkp_spa = 64'h6_0000; lkp_access = A_READ;
    @(posedge clk); #1;
    rst = 1'b0;
    lkp_valid = 1'b0;
    exp_hits = 0; exp_miss = 0;
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check_cnt("midrst");
    lookup(6'd7, 64'h6_0000, A_READ, 0, 3'b000, 0, "post_rst_miss");
    check_cnt("post_rst");

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
